// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock and releases periph then core reset; release after SYNC+LOCK / SYNC+LOCK+GAP edges, no backpressure.
// Define PLL_RSTSEQ_LOSS_CNT_EN to add the saturating loss_count output.
module pll_reset_sequencer #(
    parameter int LOCK_CYCLES = 1024,
    parameter int GAP_CYCLES  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       ext_rst,
    output logic       periph_rst_n,
    output logic       core_rst_n,
    output logic       ready
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    ,
    output logic [7:0] loss_count
`endif
);

    localparam int MAX_CYC = (LOCK_CYCLES > GAP_CYCLES) ? LOCK_CYCLES : GAP_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABLE    = 2'd1,
        S_GAP       = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] ext_sync_q;
    logic                   locked_s;
    logic                   ext_s;
    logic                   abort;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          periph_q, periph_d;
    logic          core_q, core_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q <= '0;
            ext_sync_q  <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked};
            ext_sync_q  <= {ext_sync_q[SYNC_STAGES-2:0], ext_rst};
        end
    end

    assign locked_s = lock_sync_q[SYNC_STAGES-1];
    assign ext_s    = ext_sync_q[SYNC_STAGES-1];
    assign abort    = ext_s | ~locked_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            core_q   <= core_d;
        end
    end

    // Counter restarts at 0 on every state entry, so a lock glitch in STABLE requalifies from scratch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_WAIT_LOCK: begin
                if (!abort) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end
            end
            S_STABLE: begin
                if (abort) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they flip on the same edge as the transition.
    always_comb begin
        periph_d = 1'b0;
        core_d   = 1'b0;
        if (state_d == S_GAP || state_d == S_RUN) begin
            periph_d = 1'b1;
        end
        if (state_d == S_RUN) begin
            core_d = 1'b1;
        end
    end

    assign periph_rst_n = periph_q;
    assign core_rst_n   = core_q;
    assign ready        = core_q;

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    logic       lock_loss;
    logic [7:0] loss_q, loss_d;

    // External requests take priority, so a simultaneous request and loss is not a counted loss.
    assign lock_loss = ((state_q == S_GAP) || (state_q == S_RUN)) && !ext_s && !locked_s;

    always_comb begin
        loss_d = loss_q;
        if (lock_loss && (loss_q != 8'hFF)) begin
            loss_d = loss_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= 8'd0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign loss_count = loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with LOCK_CYCLES=8, GAP_CYCLES=4, SYNC_STAGES=2.
module tb_pll_reset_sequencer;

    logic clk;
    logic rst_n;
    logic locked;
    logic ext_rst;
    logic periph_rst_n;
    logic core_rst_n;
    logic ready;
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    logic [7:0] loss_count;
    int         exp_loss;
`endif

    int checks;
    int errors;

    pll_reset_sequencer #(
        .LOCK_CYCLES(8),
        .GAP_CYCLES (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .locked      (locked),
        .ext_rst     (ext_rst),
        .periph_rst_n(periph_rst_n),
        .core_rst_n  (core_rst_n),
        .ready       (ready)
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
        ,
        .loss_count  (loss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; called right after a change, tick(k) lands just after edge k-1.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        if ({periph_rst_n, core_rst_n, ready} !== 3'b000) begin
            errors++; $display("FAIL reset_async: got %b exp 000", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(3);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b000) begin
            errors++; $display("FAIL reset_held: got %b exp 000", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
        if (loss_count !== 8'd0) begin
            errors++; $display("FAIL reset_loss: got %0d exp 0", loss_count);
        end
        checks++;
`endif
    endtask

    task automatic test_power_on();
        rst_n  = 1'b1;
        locked = 1'b1;
        tick(10);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b000) begin
            errors++; $display("FAIL pon_e9: got %b exp 000", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(1);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b100) begin
            errors++; $display("FAIL pon_e10: got %b exp 100", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(3);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b100) begin
            errors++; $display("FAIL pon_e13: got %b exp 100", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(1);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b111) begin
            errors++; $display("FAIL pon_e14: got %b exp 111", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
    endtask

    task automatic test_lock_glitch();
        // Leave RUN through a lock loss, then requalify with a glitch late in STABLE.
        locked = 1'b0;
        tick(4);
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
        exp_loss++;
`endif
        locked = 1'b1;
        tick(8);
        locked = 1'b0;
        tick(3);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b000) begin
            errors++; $display("FAIL glitch_e10: got %b exp 000", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        locked = 1'b1;
        tick(10);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b000) begin
            errors++; $display("FAIL glitch_relock_e9: got %b exp 000", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(1);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b100) begin
            errors++; $display("FAIL glitch_relock_e10: got %b exp 100", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(4);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b111) begin
            errors++; $display("FAIL glitch_relock_e14: got %b exp 111", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
        if (loss_count !== 8'(exp_loss)) begin
            errors++; $display("FAIL glitch_loss: got %0d exp %0d", loss_count, exp_loss);
        end
        checks++;
`endif
    endtask

    task automatic test_lock_loss();
        locked = 1'b0;
        tick(2);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b111) begin
            errors++; $display("FAIL loss_e1: got %b exp 111", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(1);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b000) begin
            errors++; $display("FAIL loss_e2: got %b exp 000", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
        exp_loss++;
        if (loss_count !== 8'(exp_loss)) begin
            errors++; $display("FAIL loss_count_inc: got %0d exp %0d", loss_count, exp_loss);
        end
        checks++;
`endif
        locked = 1'b1;
        tick(10);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b000) begin
            errors++; $display("FAIL loss_relock_e9: got %b exp 000", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(1);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b100) begin
            errors++; $display("FAIL loss_relock_e10: got %b exp 100", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(3);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b100) begin
            errors++; $display("FAIL loss_relock_e13: got %b exp 100", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(1);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b111) begin
            errors++; $display("FAIL loss_relock_e14: got %b exp 111", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
    endtask

    task automatic test_ext_reset();
        ext_rst = 1'b1;
        tick(2);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b111) begin
            errors++; $display("FAIL ext_e1: got %b exp 111", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(1);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b000) begin
            errors++; $display("FAIL ext_e2: got %b exp 000", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(2);
        ext_rst = 1'b0;
        tick(10);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b000) begin
            errors++; $display("FAIL ext_rel_e9: got %b exp 000", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(1);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b100) begin
            errors++; $display("FAIL ext_rel_e10: got %b exp 100", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        tick(4);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b111) begin
            errors++; $display("FAIL ext_rel_e14: got %b exp 111", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
        if (loss_count !== 8'(exp_loss)) begin
            errors++; $display("FAIL ext_loss_unchanged: got %0d exp %0d", loss_count, exp_loss);
        end
        checks++;
`endif
    endtask

    task automatic test_simultaneous();
        ext_rst = 1'b1;
        tick(3);
        ext_rst = 1'b0;
        tick(11);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b100) begin
            errors++; $display("FAIL simul_in_gap: got %b exp 100", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        locked  = 1'b0;
        ext_rst = 1'b1;
        tick(3);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b000) begin
            errors++; $display("FAIL simul_abort: got %b exp 000", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
        if (loss_count !== 8'(exp_loss)) begin
            errors++; $display("FAIL simul_loss_unchanged: got %0d exp %0d", loss_count, exp_loss);
        end
        checks++;
`endif
        locked  = 1'b1;
        ext_rst = 1'b0;
        tick(15);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b111) begin
            errors++; $display("FAIL simul_rerelease: got %b exp 111", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
    endtask

    task automatic test_saturate_and_reset();
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            tick(3);
            locked = 1'b1;
            tick(15);
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
            if (exp_loss < 255) exp_loss++;
`endif
        end
        if ({periph_rst_n, core_rst_n, ready} !== 3'b111) begin
            errors++; $display("FAIL sat_run: got %b exp 111", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
        if (loss_count !== 8'(exp_loss) || exp_loss != 255) begin
            errors++; $display("FAIL sat_loss: got %0d exp 255", loss_count);
        end
        checks++;
`endif
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        tick(12);
        if ({periph_rst_n, core_rst_n, ready} !== 3'b100) begin
            errors++; $display("FAIL sat_mid_gap: got %b exp 100", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
        // Assert reset between clock edges; outputs must clear without any rising edge.
        #2;
        rst_n = 1'b0;
        #1;
        if ({periph_rst_n, core_rst_n, ready} !== 3'b000) begin
            errors++; $display("FAIL async_clear: got %b exp 000", {periph_rst_n, core_rst_n, ready});
        end
        checks++;
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
        if (loss_count !== 8'd0) begin
            errors++; $display("FAIL async_loss_clear: got %0d exp 0", loss_count);
        end
        checks++;
`endif
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        locked  = 1'b0;
        ext_rst = 1'b0;
`ifdef PLL_RSTSEQ_LOSS_CNT_EN
        exp_loss = 0;
`endif
        test_reset();
        test_power_on();
        test_lock_glitch();
        test_lock_loss();
        test_ext_reset();
        test_simultaneous();
        test_saturate_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
